// File: rtl/score_display_pkg.sv
// Shared constants, FSM encoding and seven-segment decode for the score display.
package score_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [15:0] MAX_DISPLAY = 16'd9999;

  // Active-low segments, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } convState_t;

  function automatic logic [6:0] segDecode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter using one double-dabble step per cycle.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [1:0]  dbgState
);

  // Handshake: start is accepted only in a cycle where busy is low; bin is
  // captured in that same cycle. busy stays high from the next cycle until the
  // conversion ends, and done pulses for exactly one cycle (the LOAD cycle)
  // while bcd holds the finished result. start while busy is ignored.

  convState_t  state, stateNext;
  logic [31:0] shiftQ, shiftNext;
  logic [3:0]  cnt, cntNext;

  function automatic logic [31:0] dabbleStep(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[16 + 4*i +: 4] >= 4'd5) begin
        t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[30:0], 1'b0};
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      shiftQ <= '0;
      cnt    <= '0;
    end else begin
      state  <= stateNext;
      shiftQ <= shiftNext;
      cnt    <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    shiftNext = shiftQ;
    cntNext   = cnt;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          shiftNext = {16'd0, bin};
          cntNext   = 4'd0;
          stateNext = CONV;
        end
      end
      CONV: begin
        shiftNext = dabbleStep(shiftQ);
        cntNext   = cnt + 4'd1;
        if (cnt == 4'd15) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign bcd      = shiftQ[31:16];
  assign dbgState = state;

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display: detects score changes, clamps to 9999,
// converts to BCD in the background and scans the digits with leading-zero blanking.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_W = 20,
  parameter int BLANK_LZ  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] score,
  output logic [3:0]  anode,
  output logic [6:0]  ssdOut,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  dbgState
);

  logic        convBusy;
  logic        convDone;
  logic [15:0] convBcd;
  logic        start;
  logic [15:0] clamped;
  logic [15:0] rawQ;
  logic [15:0] lastScore;
  logic [15:0] digitsQ;

  logic [REFRESH_W-1:0] refreshQ;
  logic [1:0]           sel;
  logic [3:0]           curDigit;
  logic [3:0]           leadZero;
  logic [3:0]           anodeNext;

  // A change arriving mid-conversion is simply seen again on the next idle cycle.
  assign start   = !convBusy && (score != lastScore);
  assign clamped = (score > MAX_DISPLAY) ? MAX_DISPLAY : score;

  bin2bcd_seq u_conv (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .bin      (clamped),
    .busy     (convBusy),
    .done     (convDone),
    .bcd      (convBcd),
    .dbgState (dbgState)
  );

  // The raw score, not the clamped one, is remembered so overflow and change
  // detection refer to what the game actually reported.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rawQ      <= '0;
      lastScore <= '0;
      digitsQ   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (start) begin
        rawQ <= score;
      end
      if (convDone) begin
        digitsQ   <= convBcd;
        lastScore <= rawQ;
        overflow  <= (rawQ > MAX_DISPLAY);
      end
    end
  end

  assign busy     = convBusy;
  assign sel      = refreshQ[REFRESH_W-1:REFRESH_W-2];
  assign curDigit = digitsQ[{sel, 2'b00} +: 4];

  always_comb begin
    leadZero    = 4'b0000;
    leadZero[3] = (digitsQ[15:12] == 4'd0);
    leadZero[2] = leadZero[3] && (digitsQ[11:8] == 4'd0);
    leadZero[1] = leadZero[2] && (digitsQ[7:4] == 4'd0);
    anodeNext   = ~(4'b0001 << sel);
    if ((BLANK_LZ != 0) && leadZero[sel]) begin
      anodeNext = 4'b1111;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      refreshQ <= '0;
      anode    <= 4'b1110;
      ssdOut   <= SEG_0;
    end else begin
      refreshQ <= refreshQ + {{(REFRESH_W-1){1'b0}}, 1'b1};
      anode    <= anodeNext;
      ssdOut   <= segDecode(curDigit);
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: table of scores with expected BCD/overflow,
// plus hand sequences for reset, back-to-back changes and reset mid-conversion.
module tb_score_display;

  typedef struct {
    logic [15:0] score;
    logic [15:0] expBcd;
    logic        expOvf;
  } vec_t;

  localparam int NUM_VECS = 10;

  logic        clk;
  logic        reset;
  logic [15:0] score;
  logic [3:0]  anode, nbAnode;
  logic [6:0]  ssdOut, nbSsdOut;
  logic        busy, nbBusy;
  logic        overflow, nbOverflow;
  logic [1:0]  dbgState, nbDbgState;

  vec_t        vecs[NUM_VECS];
  logic [16:0] exp_q[$];
  logic [6:0]  segTab[10];
  int          checks = 0;
  int          errors = 0;
  int          busyPulses = 0;
  logic        busyPrev = 1'b0;

  score_display #(.REFRESH_W(4), .BLANK_LZ(1)) dut (
    .Clk(clk), .Reset(reset), .score(score), .anode(anode), .ssdOut(ssdOut),
    .busy(busy), .overflow(overflow), .dbgState(dbgState)
  );

  score_display #(.REFRESH_W(4), .BLANK_LZ(0)) dutNb (
    .Clk(clk), .Reset(reset), .score(score), .anode(nbAnode), .ssdOut(nbSsdOut),
    .busy(nbBusy), .overflow(nbOverflow), .dbgState(nbDbgState)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (busy && !busyPrev) busyPulses++;
    busyPrev = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int segToDigit(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (segTab[i] == s) return i;
    end
    return 15;
  endfunction

  function automatic logic [3:0] expMask(input logic [15:0] bcd);
    logic [3:0] m;
    m = 4'b0001;
    for (int k = 1; k < 4; k++) begin
      if ((bcd >> (4 * k)) != 16'd0) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Wait until busy drops after having been high; returns the high-cycle count.
  task automatic waitIdle(input string name, output int hi);
    logic seen;
    bit   finished;
    seen     = busy;
    hi       = 0;
    finished = 0;
    for (int i = 0; i < 60 && !finished; i++) begin
      tick();
      if (busy) begin
        hi++;
        seen = 1'b1;
      end else if (seen) begin
        finished = 1;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still %0b after 60 cycles, required 0", name, busy);
    end
  endtask

  // Scoreboard pop: scan one full refresh period and compare against the head of exp_q.
  task automatic scanCheck(input string name);
    logic [16:0] exp;
    logic [3:0]  dig[4];
    logic [3:0]  lowMask, nbLowMask, dig0Blanked;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue: got empty expected queue, required an entry", name);
      return;
    end
    exp = exp_q.pop_front();
    for (int k = 0; k < 4; k++) dig[k] = 4'hF;
    lowMask     = 4'b0000;
    nbLowMask   = 4'b0000;
    dig0Blanked = 4'hF;
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (nbAnode == ~(4'b0001 << k)) dig[k] = 4'(segToDigit(nbSsdOut));
      end
      if (anode == 4'b1110) dig0Blanked = 4'(segToDigit(ssdOut));
      lowMask   = lowMask | ~anode;
      nbLowMask = nbLowMask | ~nbAnode;
    end
    check({name, "_digits"}, {dig[3], dig[2], dig[1], dig[0]}, exp[15:0]);
    check({name, "_blank_mask"}, lowMask, expMask(exp[15:0]));
    check({name, "_noblank_mask"}, nbLowMask, 4'b1111);
    check({name, "_digit0"}, dig0Blanked, exp[3:0]);
    check({name, "_overflow"}, overflow, exp[16]);
  endtask

  initial begin
    int hi;
    int pulses0;

    segTab[0] = 7'b0000001; segTab[1] = 7'b1001111; segTab[2] = 7'b0010010;
    segTab[3] = 7'b0000110; segTab[4] = 7'b1001100; segTab[5] = 7'b0100100;
    segTab[6] = 7'b0100000; segTab[7] = 7'b0001111; segTab[8] = 7'b0000000;
    segTab[9] = 7'b0000100;

    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd12345, 16'h9999, 1'b1};
    vecs[2] = '{16'd42,    16'h0042, 1'b0};
    vecs[3] = '{16'd9999,  16'h9999, 1'b0};
    vecs[4] = '{16'd7,     16'h0007, 1'b0};
    vecs[5] = '{16'd0,     16'h0000, 1'b0};
    vecs[6] = '{16'd1000,  16'h1000, 1'b0};
    vecs[7] = '{16'd305,   16'h0305, 1'b0};
    vecs[8] = '{16'd10000, 16'h9999, 1'b1};
    vecs[9] = '{16'd65535, 16'h9999, 1'b1};

    // Reset with score 0
    reset = 1'b1;
    score = 16'd0;
    repeat (3) tick();
    check("rst_anode", anode, 4'b1110);
    check("rst_ssd", ssdOut, 7'b0000001);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", dbgState, 2'd0);
    check("rst_nb_anode", nbAnode, 4'b1110);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_no_conv", busy, 1'b0);

    // Table-driven conversions
    for (int i = 0; i < NUM_VECS; i++) begin
      score = vecs[i].score;
      exp_q.push_back({vecs[i].expOvf, vecs[i].expBcd});
      tick();
      check($sformatf("v%0d_busy_start", i), busy, 1'b1);
      waitIdle($sformatf("v%0d", i), hi);
      check($sformatf("v%0d_busy_len", i), hi, 16);
      check($sformatf("v%0d_ovf_at_load", i), overflow, vecs[i].expOvf);
      scanCheck($sformatf("v%0d", i));
    end

    // Reset in the middle of a conversion, then restart on release
    score = 16'd5555;
    tick();
    repeat (7) tick();
    check("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_anode", anode, 4'b1110);
    check("midrst_ssd", ssdOut, 7'b0000001);
    check("midrst_overflow", overflow, 1'b0);
    reset = 1'b0;
    exp_q.push_back({1'b0, 16'h5555});
    tick();
    check("release_busy", busy, 1'b1);
    waitIdle("release", hi);
    scanCheck("release");

    // Score change during a conversion is converted afterwards
    pulses0 = busyPulses;
    score = 16'd100;
    exp_q.push_back({1'b0, 16'h0100});
    repeat (5) tick();
    score = 16'd200;
    exp_q.push_back({1'b0, 16'h0200});
    waitIdle("pair_first", hi);
    scanCheck("pair_first");
    waitIdle("pair_second", hi);
    scanCheck("pair_second");
    check("pair_pulses", busyPulses - pulses0, 2);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter REFRESH_W, default 20, width of the free-running refresh counter; its top two bits select the digit.
REQ-002 Parameter BLANK_LZ, default 1, enables leading-zero blanking when 1.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Clk  input  1  system clock (100 MHz board clock).
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 score  input  16  unsigned binary score from the game FSM.
REQ-007 anode  output  4  active-low digit enables; bit k drives digit k, digit 0 is rightmost.
REQ-008 ssdOut  output  7  active-low segments, bit order {Ca,Cb,Cc,Cd,Ce,Cf,Cg} = ssdOut[6:0].
REQ-009 busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-010 overflow  output  1  high while the displayed value is clamped.

Function
REQ-011 FSM states SHALL be IDLE, CONV and LOAD.
REQ-012 IDLE: when score != last_score, capture min(score, 9999) into the shift register, set cnt=0, and go to CONV.
REQ-013 CONV SHALL run exactly 16 cycles of double-dabble (add-3 on any BCD nibble >=5, then shift left 1) and go to LOAD when cnt==15.
REQ-014 LOAD SHALL take one cycle: digits_q <= BCD result, last_score <= raw score captured in IDLE, overflow <= (captured raw > 9999); then go to IDLE.
REQ-015 Latency: score change seen in IDLE at cycle N -> digits_q valid at N+18; busy high N+1..N+17 inclusive.
REQ-016 A score change during CONV/LOAD SHALL NOT abort the conversion; it is detected in the next IDLE cycle and converted then.
REQ-017 Scores 9999 and below SHALL display exactly; scores 10000..65535 SHALL display 9999 with overflow=1.
REQ-018 The refresh counter SHALL increment every cycle and wrap modulo 2^REFRESH_W; sel = counter[REFRESH_W-1:REFRESH_W-2].
REQ-019 anode and ssdOut SHALL be registered: one cycle after sel changes, anode = ~(1<<sel) and ssdOut = the decode of digits_q[sel].
REQ-020 Blanking: with BLANK_LZ=1, digit k>=1 SHALL have anode bit forced high when digits_q[3:k] are all zero; digit 0 is never blanked.
REQ-021 The segment decode SHALL map 0-9 to standard patterns; nibbles 10-15 are unreachable and SHALL decode to all-off (7'b1111111).
REQ-022 Segment patterns for 0 and 8 SHALL be 7'b0000001 and 7'b0000000 respectively.

Reset
REQ-023 On Reset: state=IDLE, cnt=0, digits_q=0, last_score=0, refresh counter=0, busy=0, overflow=0.
REQ-024 Registered outputs after Reset SHALL be anode=4'b1110 and ssdOut=7'b0000001 (a single "0" shown).
REQ-025 Reset asserted mid-conversion SHALL discard the conversion; busy=0 on the following cycle.
REQ-026 If score is nonzero at Reset release, a conversion SHALL start in the first IDLE cycle.

Structure
REQ-027 Package score_display_pkg SHALL hold NUM_DIGITS=4, MAX_DISPLAY=16'd9999, the segment pattern constants and the FSM state encoding.
REQ-028 The sequential converter SHALL be sub-module bin2bcd_seq (ports: Clk, Reset, start, bin[15:0], busy, done, bcd[15:0]).
REQ-029 score_display SHALL contain the change detector, clamp, refresh/mux and decode logic.
REQ-030 Benches SHALL override REFRESH_W to 4.

Verification
REQ-031 Reset with score=0 -> anode=4'b1110, ssdOut=7'b0000001, busy=0, overflow=0.
REQ-032 score 0->1234 at cycle N -> busy high N+1..N+17, digits_q=4'h1234 at N+18; the scan shows 4,3,2,1 on anodes 0..3.
REQ-033 score=12345 -> digits_q=4'h9999, overflow=1; then score=42 -> digits_q=4'h0042, overflow=0.
REQ-034 score=7 with BLANK_LZ=1 -> only anode[0] ever low, ssdOut=7'b0001111; with BLANK_LZ=0 -> all four anodes cycle, digits 3..1 show "0".
REQ-035 score=100, then 200 at N+5 -> first conversion completes with 0100, second completes with 0200; exactly two busy pulses.
REQ-036 Reset asserted at N+8 of a conversion -> next cycle busy=0, digits_q=0, anode=4'b1110.
